csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
Parameters:
REQ-001 The block SHALL have parameter HART_ID, default 0, giving the value read from mhartid.
REQ-002 The block SHALL have parameter MTVEC_RST, default 64'h0, giving the reset value of mtvec.

Ports (width XLEN = 64 from package riscv):
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port csr_req_v_i, input, 1 bit, CSR access request valid.
REQ-006 The block SHALL have port csr_req_rdy_o, output, 1 bit, request ready.
REQ-007 The block SHALL have port csr_adr_i, input, 12 bits, CSR address of type csr_reg_t.
REQ-008 The block SHALL have port csr_op_i, input, 2 bits, of type csr_op_t: RW=01, RS=10, RC=11.
REQ-009 The block SHALL have port csr_wdata_i, input, XLEN bits, the rs1/uimm operand.
REQ-010 The block SHALL have port csr_src_zero_i, input, 1 bit, high when rs1=x0 or uimm=0.
REQ-011 The block SHALL have port csr_rsp_v_o, output, 1 bit, response valid.
REQ-012 The block SHALL have port csr_rsp_rdy_i, input, 1 bit, response accepted.
REQ-013 The block SHALL have port csr_rdata_o, output, XLEN bits, the old CSR value.
REQ-014 The block SHALL have port csr_illegal_o, output, 1 bit, illegal access, qualified by csr_rsp_v_o.
REQ-015 The block SHALL have port instr_ret_i, input, 1 bit, one instruction retired this cycle.
REQ-016 The block SHALL have ports trap_v_i (1 bit), trap_pc_i (XLEN), trap_cause_i (XLEN) and trap_tval_i (XLEN), all inputs, for trap entry.
REQ-017 The block SHALL have port mret_i, input, 1 bit, MRET committed.
REQ-018 The block SHALL have ports mtvec_o (XLEN), mepc_o (XLEN) and mie_glb_o (1 bit, mstatus.MIE), all outputs.

Function
REQ-019 The block SHALL use an FSM with states IDLE and RESP.
REQ-020 csr_req_rdy_o SHALL equal (state==IDLE) & ~trap_v_i & ~mret_i.
REQ-021 A request SHALL be accepted when csr_req_v_i & csr_req_rdy_o, and the FSM SHALL then go IDLE->RESP.
REQ-022 In RESP, csr_rsp_v_o=1 and rdata/illegal SHALL be held stable until csr_rsp_rdy_i; the FSM SHALL go RESP->IDLE on csr_rsp_v_o & csr_rsp_rdy_i.
REQ-023 Latency SHALL be 1 cycle (acceptance to rsp_v) and throughput at most one access per 2 cycles.
REQ-024 csr_rdata_o SHALL be the pre-write value, captured at acceptance.
REQ-025 The new value SHALL be: RW: wdata; RS: old|wdata; RC: old&~wdata.
REQ-026 A write SHALL be effective when op=RW, or when op is RS/RC with csr_src_zero_i=0.
REQ-027 The write SHALL be committed in the acceptance cycle.
REQ-028 An access SHALL be illegal if the address is unimplemented, or if adr[11:10]==2'b11 with an effective write.
REQ-029 An illegal access SHALL change no state and SHALL return rdata=0 with illegal=1.
REQ-030 Implemented CSRs SHALL be: mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip, mcycle, minstret, cycle, instret, mvendorid, marchid, mimpid, mhartid.
REQ-031 mstatus: only MIE[3] and MPIE[7] SHALL be writable; MPP[12:11] SHALL be hardwired 2'b11; all other bits SHALL read 0.
REQ-032 misa SHALL read constant 64'h8000_0000_0000_1100 (MXL=2, I, M); writes SHALL be ignored without illegal.
REQ-033 mie: only bits 3, 7 and 11 SHALL be writable; mip SHALL read 0, and writes to it SHALL be ignored without illegal.
REQ-034 mtvec[1:0] and mepc[1:0] SHALL be forced to 0 on every write.
REQ-035 mvendorid, marchid and mimpid SHALL read 0; mhartid SHALL read HART_ID.
REQ-036 mcycle SHALL increment every cycle and minstret SHALL increment when instr_ret_i=1; both SHALL wrap from 2^64-1 to 0.
REQ-037 An effective CSR write to a counter SHALL override that cycle's increment.
REQ-038 cycle and instret SHALL be read-only shadows of mcycle and minstret.
REQ-039 On trap_v_i: mepc<=trap_pc_i&~3, mcause<=trap_cause_i, mtval<=trap_tval_i, MPIE<=MIE, MIE<=0.
REQ-040 On mret_i: MIE<=MPIE and MPIE<=1.
REQ-041 If trap_v_i and mret_i are asserted together, trap SHALL win.
REQ-042 A trap or mret arriving during RESP SHALL update state and SHALL NOT alter the held response.

Reset
REQ-043 Async reset SHALL force: FSM=IDLE, csr_rsp_v_o=0, csr_rdata_o=0, csr_illegal_o=0, mstatus=64'h1800, mtvec=MTVEC_RST, and all other CSRs and counters=0.
REQ-044 Reset mid-response SHALL drop the pending response.
REQ-045 csr_req_rdy_o SHALL be 1 in the first cycle after release of reset, unless trap_v_i or mret_i is asserted.

Structure
REQ-046 csr_op_t, the MISA value constant and the mstatus bit-position localparams SHALL be placed in package riscv.
REQ-047 The block SHALL contain one sub-module csr_counter (64-bit counter with increment enable and write port, write priority), instantiated for mcycle and minstret.

Verification
REQ-048 RS mscratch: RW mscratch=0xF0, then RS wdata=0x0F -> rdata=0xF0; a subsequent read -> 0xFF, illegal=0.
REQ-049 RW cycle (0xC00) with wdata=5 -> illegal=1, rdata=0, cycle unchanged; RS cycle with csr_src_zero_i=1 -> illegal=0, rdata=current count.
REQ-050 RW mcycle=64'hFFFF_FFFF_FFFF_FFFF -> next-cycle read of mcycle returns 0 (wrap), then increments by 1 per cycle.
REQ-051 Set MIE=1; trap_v_i with pc=0x1002, cause=11 -> mepc=0x1000, mcause=11, MIE=0, MPIE=1; mret_i -> MIE=1, MPIE=1.
REQ-052 csr_rsp_rdy_i held low 3 cycles -> rsp_v and rdata stable; csr_req_rdy_o=0 throughout; new request accepted the cycle after the handshake.
REQ-053 reset_n asserted during RESP -> rsp_v=0 immediately; mstatus reads 0x1800 after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Package riscv: shared CSR types and constants for the machine-mode CSR file.
//   XLEN            - datapath width
//   csr_reg_t       - 12-bit CSR address, plus named addresses of implemented CSRs
//   csr_op_t        - CSR access operation (RW / RS / RC)
//   state_e         - request/response FSM states
//   MISA_VAL        - constant misa value (MXL=2, I, M)
//   MSTATUS_*_BIT   - mstatus bit positions
//   csr_apply_op    - computes the post-write value of a CSR from the operation
package riscv;

  localparam int XLEN = 64;

  typedef logic [11:0] csr_reg_t;

  localparam csr_reg_t CSR_MSTATUS   = 12'h300;
  localparam csr_reg_t CSR_MISA      = 12'h301;
  localparam csr_reg_t CSR_MIE       = 12'h304;
  localparam csr_reg_t CSR_MTVEC     = 12'h305;
  localparam csr_reg_t CSR_MSCRATCH  = 12'h340;
  localparam csr_reg_t CSR_MEPC      = 12'h341;
  localparam csr_reg_t CSR_MCAUSE    = 12'h342;
  localparam csr_reg_t CSR_MTVAL     = 12'h343;
  localparam csr_reg_t CSR_MIP       = 12'h344;
  localparam csr_reg_t CSR_MCYCLE    = 12'hB00;
  localparam csr_reg_t CSR_MINSTRET  = 12'hB02;
  localparam csr_reg_t CSR_CYCLE     = 12'hC00;
  localparam csr_reg_t CSR_INSTRET   = 12'hC02;
  localparam csr_reg_t CSR_MVENDORID = 12'hF11;
  localparam csr_reg_t CSR_MARCHID   = 12'hF12;
  localparam csr_reg_t CSR_MIMPID    = 12'hF13;
  localparam csr_reg_t CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0000_1100;

  localparam int MSTATUS_MIE_BIT    = 3;
  localparam int MSTATUS_MPIE_BIT   = 7;
  localparam int MSTATUS_MPP_LO_BIT = 11;
  localparam int MSTATUS_MPP_HI_BIT = 12;

  // Writable bits of mie: MSIE, MTIE, MEIE.
  localparam logic [XLEN-1:0] MIE_WMASK = 64'h0000_0000_0000_0888;

  function automatic logic [XLEN-1:0] csr_apply_op(input csr_op_t op,
                                                   input logic [XLEN-1:0] old_val,
                                                   input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// csr_counter: 64-bit free-running counter with increment enable and a
// write port; a write in the same cycle replaces the increment.
//   clk, reset_n - clock, asynchronous active-low reset (clears to 0)
//   inc_i        - add one this cycle (wraps from all-ones to 0)
//   we_i/wdata_i - load wdata_i this cycle (priority over inc_i)
//   cnt_o        - current count
module csr_counter
  import riscv::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] cnt_o
);

  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] cnt_d;

  // Next count: write beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (we_i) begin
      cnt_d = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with a valid/ready request port and a
// registered response port (one access in flight, response one cycle after
// acceptance, held until accepted).
//   csr_req_*      - request: address, op (RW/RS/RC), operand, operand-is-zero
//   csr_rsp_*      - response: old CSR value and illegal flag
//   instr_ret_i    - retire pulse for minstret
//   trap_*/mret_i  - trap entry and return side channels (trap wins)
//   mtvec_o, mepc_o, mie_glb_o - live CSR values for the pipeline
module csr_file
  import riscv::*;
#(
  parameter int unsigned     HART_ID   = 0,
  parameter logic [XLEN-1:0] MTVEC_RST = 64'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_req_v_i,
  output logic            csr_req_rdy_o,
  input  csr_reg_t        csr_adr_i,
  input  csr_op_t         csr_op_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_src_zero_i,
  output logic            csr_rsp_v_o,
  input  logic            csr_rsp_rdy_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            instr_ret_i,
  input  logic            trap_v_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_glb_o
);

  state_e          state_q, state_d;
  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_csr_q, mie_csr_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] mcycle_s, minstret_s, mstatus_s, rd_val_s, new_val_s;
  logic            rd_impl_s, eff_wr_s, illegal_s, req_acc_s, csr_we_s;

  assign csr_req_rdy_o = (state_q == ST_IDLE) & ~trap_v_i & ~mret_i;
  assign req_acc_s     = csr_req_v_i & csr_req_rdy_o;
  assign eff_wr_s      = (csr_op_i == CSR_OP_RW) |
                         (((csr_op_i == CSR_OP_RS) | (csr_op_i == CSR_OP_RC)) & ~csr_src_zero_i);
  // Address space 0xC00-0xFFF is read-only; only an effective write there is illegal.
  assign illegal_s     = ~rd_impl_s | ((csr_adr_i[11:10] == 2'b11) & eff_wr_s);
  assign csr_we_s      = req_acc_s & eff_wr_s & ~illegal_s;
  assign new_val_s     = csr_apply_op(csr_op_i, rd_val_s, csr_wdata_i);

  // mstatus view: MIE/MPIE stored, MPP hardwired to M-mode, rest zero.
  always_comb begin
    mstatus_s                     = '0;
    mstatus_s[MSTATUS_MIE_BIT]    = mst_mie_q;
    mstatus_s[MSTATUS_MPIE_BIT]   = mst_mpie_q;
    mstatus_s[MSTATUS_MPP_LO_BIT] = 1'b1;
    mstatus_s[MSTATUS_MPP_HI_BIT] = 1'b1;
  end

  // Read mux and implemented-address decode.
  always_comb begin
    rd_val_s  = '0;
    rd_impl_s = 1'b1;
    case (csr_adr_i)
      CSR_MSTATUS:                rd_val_s = mstatus_s;
      CSR_MISA:                   rd_val_s = MISA_VAL;
      CSR_MIE:                    rd_val_s = mie_csr_q;
      CSR_MTVEC:                  rd_val_s = mtvec_q;
      CSR_MSCRATCH:               rd_val_s = mscratch_q;
      CSR_MEPC:                   rd_val_s = mepc_q;
      CSR_MCAUSE:                 rd_val_s = mcause_q;
      CSR_MTVAL:                  rd_val_s = mtval_q;
      CSR_MIP:                    rd_val_s = '0;
      CSR_MCYCLE, CSR_CYCLE:      rd_val_s = mcycle_s;
      CSR_MINSTRET, CSR_INSTRET:  rd_val_s = minstret_s;
      CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID:                 rd_val_s = '0;
      CSR_MHARTID:                rd_val_s = 64'(HART_ID);
      default: begin
        rd_val_s  = '0;
        rd_impl_s = 1'b0;
      end
    endcase
  end

  // CSR next state: trap, then mret, then a CSR write (the first two block acceptance).
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_csr_d  = mie_csr_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_v_i) begin
      mepc_d     = trap_pc_i & ~64'd3;
      mcause_d   = trap_cause_i;
      mtval_d    = trap_tval_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (csr_we_s) begin
      case (csr_adr_i)
        CSR_MSTATUS: begin
          mst_mie_d  = new_val_s[MSTATUS_MIE_BIT];
          mst_mpie_d = new_val_s[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_csr_d  = new_val_s & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = new_val_s & ~64'd3;
        CSR_MSCRATCH: mscratch_d = new_val_s;
        CSR_MEPC:     mepc_d     = new_val_s & ~64'd3;
        CSR_MCAUSE:   mcause_d   = new_val_s;
        CSR_MTVAL:    mtval_d    = new_val_s;
        default:      mscratch_d = mscratch_q;
      endcase
    end else begin
      mtval_d = mtval_q;
    end
  end

  // FSM next state and response capture at acceptance.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (req_acc_s) begin
          state_d   = ST_RESP;
          rdata_d   = illegal_s ? '0 : rd_val_s;
          illegal_d = illegal_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (csr_rsp_rdy_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, response and CSR registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_csr_q  <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      illegal_q  <= illegal_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_csr_q  <= mie_csr_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter u_mcycle (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (1'b1),
    .we_i    (csr_we_s & (csr_adr_i == CSR_MCYCLE)),
    .wdata_i (new_val_s),
    .cnt_o   (mcycle_s)
  );

  csr_counter u_minstret (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (instr_ret_i),
    .we_i    (csr_we_s & (csr_adr_i == CSR_MINSTRET)),
    .wdata_i (new_val_s),
    .cnt_o   (minstret_s)
  );

  assign csr_rsp_v_o   = (state_q == ST_RESP);
  assign csr_rdata_o   = rdata_q;
  assign csr_illegal_o = illegal_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mie_glb_o     = mst_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Testbench for csr_file: directed scenarios plus randomized traffic, all
// checked against a behavioural CSR model kept in the bench.
module tb_csr_file;
  import riscv::*;

  localparam int unsigned     HART = 3;
  localparam logic [63:0]     MTV  = 64'h0000_0000_8000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        csr_req_v, csr_req_rdy_o, csr_src_zero, csr_rsp_v_o, csr_rsp_rdy;
  logic [11:0] csr_adr;
  csr_op_t     csr_op;
  logic [63:0] csr_wdata, csr_rdata_o;
  logic        csr_illegal_o, instr_ret, trap_v, mret, mie_glb_o;
  logic [63:0] trap_pc, trap_cause, trap_tval, mtvec_o, mepc_o;

  always #5 clk = ~clk;

  csr_file #(.HART_ID(HART), .MTVEC_RST(MTV)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_req_v_i(csr_req_v), .csr_req_rdy_o(csr_req_rdy_o),
    .csr_adr_i(csr_adr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
    .csr_src_zero_i(csr_src_zero), .csr_rsp_v_o(csr_rsp_v_o),
    .csr_rsp_rdy_i(csr_rsp_rdy), .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o), .instr_ret_i(instr_ret),
    .trap_v_i(trap_v), .trap_pc_i(trap_pc), .trap_cause_i(trap_cause),
    .trap_tval_i(trap_tval), .mret_i(mret),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_glb_o(mie_glb_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (architectural view of the CSRs).
  bit          m_mie_bit, m_mpie_bit, m_busy, m_ill, m_accepted;
  logic [63:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret, m_rdata;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mie_bit = 0; m_mpie_bit = 0; m_busy = 0; m_ill = 0; m_accepted = 0;
    m_mie_reg = 0; m_mtvec = MTV; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mtval = 0; m_mcycle = 0; m_minstret = 0; m_rdata = 0;
  endtask

  function automatic void model_read(input logic [11:0] a, output logic [63:0] v, output bit ok);
    ok = 1;
    case (a)
      12'h300: v = 64'h1800 | (64'(m_mpie_bit) << 7) | (64'(m_mie_bit) << 3);
      12'h301: v = 64'h8000_0000_0000_1100;
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344, 12'hF11, 12'hF12, 12'hF13: v = 64'd0;
      12'hB00, 12'hC00: v = m_mcycle;
      12'hB02, 12'hC02: v = m_minstret;
      12'hF14: v = 64'(HART);
      default: begin v = 64'd0; ok = 0; end
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: begin m_mie_bit = v[3]; m_mpie_bit = v[7]; end
      12'h304: m_mie_reg = v & 64'h888;
      12'h305: m_mtvec = {v[63:2], 2'b00};
      12'h340: m_mscratch = v;
      12'h341: m_mepc = {v[63:2], 2'b00};
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      12'hB00: m_mcycle = v;
      12'hB02: m_minstret = v;
      default: ;
    endcase
  endtask

  // One clock cycle with the currently driven inputs: check ready before the
  // edge, advance the model at the edge, check the outputs just after it.
  task automatic tick();
    bit rdy, acc, ok, eff, ill;
    logic [63:0] old_v, nv;
    rdy = !m_busy && !trap_v && !mret;
    @(negedge clk);
    check_val("req_rdy", 64'(csr_req_rdy_o), 64'(rdy));
    @(posedge clk);
    acc = csr_req_v && rdy;
    m_accepted = acc;
    eff = 0; ill = 0; nv = 0; old_v = 0;
    if (m_busy && csr_rsp_rdy) m_busy = 0;
    if (acc) begin
      model_read(csr_adr, old_v, ok);
      eff = (csr_op == CSR_OP_RW) || ((csr_op == CSR_OP_RS || csr_op == CSR_OP_RC) && !csr_src_zero);
      ill = !ok || (csr_adr[11:10] == 2'b11 && eff);
      m_rdata = ill ? 64'd0 : old_v;
      m_ill = ill;
      m_busy = 1;
      case (csr_op)
        CSR_OP_RW: nv = csr_wdata;
        CSR_OP_RS: nv = old_v | csr_wdata;
        CSR_OP_RC: nv = old_v & ~csr_wdata;
        default:   nv = old_v;
      endcase
    end
    m_mcycle = m_mcycle + 64'd1;
    if (instr_ret) m_minstret = m_minstret + 64'd1;
    if (trap_v) begin
      m_mepc = {trap_pc[63:2], 2'b00}; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mpie_bit = m_mie_bit; m_mie_bit = 0;
    end else if (mret) begin
      m_mie_bit = m_mpie_bit; m_mpie_bit = 1;
    end
    if (acc && eff && !ill) model_write(csr_adr, nv);
    #1;
    check_val("rsp_v", 64'(csr_rsp_v_o), 64'(m_busy));
    check_val("rdata", csr_rdata_o, m_rdata);
    check_val("illegal", 64'(csr_illegal_o), 64'(m_ill));
    check_val("mtvec_o", mtvec_o, m_mtvec);
    check_val("mepc_o", mepc_o, m_mepc);
    check_val("mie_glb_o", 64'(mie_glb_o), 64'(m_mie_bit));
  endtask

  task automatic csr_access(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                            input bit zero, output logic [63:0] rd, output logic ill);
    int n;
    csr_req_v = 1; csr_adr = a; csr_op = csr_op_t'(op); csr_wdata = wd;
    csr_src_zero = zero; csr_rsp_rdy = 1;
    n = 0;
    do begin tick(); n++; end while (!m_accepted && n < 8);
    check_val("accepted", 64'(m_accepted), 64'd1);
    rd = csr_rdata_o; ill = csr_illegal_o;
    csr_req_v = 0;
    n = 0;
    do begin tick(); n++; end while (m_busy && n < 8);
    check_val("handshake", 64'(m_busy), 64'd0);
  endtask

  // Asynchronous reset applied between edges; release a few ns after a posedge.
  task automatic apply_reset();
    #1 reset_n = 0;
    #1;
    model_reset();
    check_val("rst_rsp_v", 64'(csr_rsp_v_o), 64'd0);
    check_val("rst_rdata", csr_rdata_o, 64'd0);
    check_val("rst_illegal", 64'(csr_illegal_o), 64'd0);
    check_val("rst_mtvec", mtvec_o, MTV);
    check_val("rst_mepc", mepc_o, 64'd0);
    check_val("rst_mie_glb", 64'(mie_glb_o), 64'd0);
    @(posedge clk);
    #3 reset_n = 1;
  endtask

  logic [11:0] addr_tbl [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hC00,
                                 12'hC02, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0,
                                 12'hC01, 12'h345};

  initial begin
    logic [63:0] rd;
    logic        ill;
    reset_n = 1; csr_req_v = 0; csr_adr = 0; csr_op = CSR_OP_NONE; csr_wdata = 0;
    csr_src_zero = 0; csr_rsp_rdy = 0; instr_ret = 0; trap_v = 0; mret = 0;
    trap_pc = 0; trap_cause = 0; trap_tval = 0;
    apply_reset();

    // Read-set on mscratch.
    csr_access(12'h340, 2'b01, 64'hF0, 0, rd, ill);
    csr_access(12'h340, 2'b10, 64'h0F, 0, rd, ill);
    check_val("rs_old", rd, 64'hF0);
    csr_access(12'h340, 2'b10, 64'h0, 1, rd, ill);
    check_val("rs_new", rd, 64'hFF);
    check_val("rs_ill", 64'(ill), 64'd0);
    csr_access(12'hF14, 2'b10, 64'h0, 1, rd, ill);
    check_val("mhartid", rd, 64'(HART));

    // Read-only counter shadow.
    csr_access(12'hC00, 2'b01, 64'd5, 0, rd, ill);
    check_val("ro_wr_ill", 64'(ill), 64'd1);
    check_val("ro_wr_rdata", rd, 64'd0);
    csr_access(12'hC00, 2'b10, 64'd0, 1, rd, ill);
    check_val("ro_rd_ill", 64'(ill), 64'd0);

    // mcycle wrap and increment.
    csr_access(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, ill);
    csr_access(12'hB00, 2'b10, 64'd0, 1, rd, ill);
    check_val("mcycle_wrap", rd, 64'd0);
    csr_access(12'hB00, 2'b10, 64'd0, 1, rd, ill);
    check_val("mcycle_inc", rd, 64'd2);

    // Trap entry and return.
    csr_access(12'h300, 2'b10, 64'h8, 0, rd, ill);
    trap_v = 1; trap_pc = 64'h1002; trap_cause = 64'd11; trap_tval = 64'h55;
    tick();
    trap_v = 0;
    check_val("trap_mepc", mepc_o, 64'h1000);
    check_val("trap_mie", 64'(mie_glb_o), 64'd0);
    csr_access(12'h342, 2'b10, 64'd0, 1, rd, ill);
    check_val("trap_mcause", rd, 64'd11);
    csr_access(12'h300, 2'b10, 64'd0, 1, rd, ill);
    check_val("trap_mstatus", rd, 64'h1880);
    mret = 1; tick(); mret = 0;
    csr_access(12'h300, 2'b10, 64'd0, 1, rd, ill);
    check_val("mret_mstatus", rd, 64'h1888);

    // Response back-pressure.
    csr_req_v = 1; csr_adr = 12'h340; csr_op = CSR_OP_NONE; csr_rsp_rdy = 0;
    tick();
    csr_adr = 12'h305;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bp_rsp_v", 64'(csr_rsp_v_o), 64'd1);
      check_val("bp_rdata", csr_rdata_o, 64'hFF);
    end
    csr_rsp_rdy = 1;
    tick();
    tick();
    check_val("bp_next_acc", 64'(m_accepted), 64'd1);
    csr_req_v = 0;
    tick();

    // Reset during a pending response.
    csr_req_v = 1; csr_adr = 12'h340; csr_rsp_rdy = 0;
    tick();
    csr_req_v = 0;
    apply_reset();
    csr_access(12'h300, 2'b10, 64'd0, 1, rd, ill);
    check_val("post_rst_mstatus", rd, 64'h1800);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      csr_req_v    = ($urandom_range(0, 2) != 0);
      csr_adr      = addr_tbl[$urandom_range(0, 19)];
      csr_op       = csr_op_t'(2'($urandom_range(0, 3)));
      csr_wdata    = ($urandom_range(0, 3) == 0) ? 64'(8'($urandom)) : {$urandom, $urandom};
      csr_src_zero = ($urandom_range(0, 7) == 0);
      csr_rsp_rdy  = ($urandom_range(0, 2) != 0);
      instr_ret    = $urandom_range(0, 1) == 1;
      trap_v       = ($urandom_range(0, 19) == 0);
      mret         = ($urandom_range(0, 19) == 0);
      trap_pc      = {$urandom, $urandom};
      trap_cause   = 64'($urandom_range(0, 15));
      trap_tval    = {$urandom, $urandom};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
